ssd_scan_driver: RTL and testbench

Time-multiplexed driver for the 8-digit common-anode seven-segment display on the Nexys A7/DDR4 board. It consumes the hex digit nibbles produced by the upstream counter stage and decodes each one to segment patterns. It scans the anodes at a fixed per-digit slot with a dead-time blanking interval, and snapshots its inputs once per frame so a value is never shown torn across digits. Sits between the counter stage and the board pins.

---
 rtl/ssd_scan_driver.sv | 149 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed driver for a common-anode 7-segment bank.
// Each digit owns a slot of REFRESH_DIV cycles. The first BLANK_CYCLES of a
// slot keep every anode off while the cathodes settle on the next pattern.
// Inputs are snapshotted once per frame, on the first edge of slot 0.
// All pins come straight from flops.
// Timing: the flops driving the pins load at edge E from the pre-edge
// cnt/idx. The anode therefore falls at E(BLANK_CYCLES) and rises at the
// next slot's E0. On a snapshot edge the incoming inputs are used directly,
// so the new values appear on the pins from that edge onward.
module ssd_scan_driver #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [4*N_DIGITS-1:0]  digits_i,
  input  logic [N_DIGITS-1:0]    dp_i,
  input  logic [N_DIGITS-1:0]    en_i,
  input  logic                   lz_blank_i,
  output logic [N_DIGITS-1:0]    an_o,
  output logic [6:0]             seg_o,
  output logic                   dp_o,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] scan_idx_o
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_dig;
  logic [N_DIGITS-1:0]   r_dp_snap;
  logic [N_DIGITS-1:0]   r_en_snap;
  logic                  r_lz_snap;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [IDX_W-1:0]      r_scan;

  logic                  w_load;
  logic [4*N_DIGITS-1:0] w_dig;
  logic [N_DIGITS-1:0]   w_dp;
  logic [N_DIGITS-1:0]   w_en;
  logic                  w_lz;
  logic [N_DIGITS-1:0]   w_zero_tail;
  logic [N_DIGITS-1:0]   w_supp;
  logic                  w_acc;
  logic [3:0]            w_nib;
  logic                  w_cur_dp;
  logic [N_DIGITS-1:0]   w_an_lit;
  logic [CNT_W-1:0]      w_cnt_inc;

  // Hex nibble to active-low segment pattern {G,F,E,D,C,B,A}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Frame-start detection, and the view of the snapshot this edge decodes from.
  always_comb begin
    w_load    = (r_state == ST_BLANK) && (r_idx == '0) && (r_cnt == '0);
    w_dig     = w_load ? digits_i   : r_dig;
    w_dp      = w_load ? dp_i       : r_dp_snap;
    w_en      = w_load ? en_i       : r_en_snap;
    w_lz      = w_load ? lz_blank_i : r_lz_snap;
    w_cnt_inc = r_cnt + 1'b1;
  end

  // Per-digit suppression: disabled, or a leading zero (never digit 0).
  always_comb begin
    w_acc       = 1'b1;
    w_zero_tail = '0;
    w_supp      = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_acc          = w_acc & (w_dig[4*k +: 4] == 4'h0);
      w_zero_tail[k] = w_acc;
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      w_supp[k] = !w_en[k] || (w_lz && (k > 0) && w_zero_tail[k]);
    end
  end

  // Pick the current digit's nibble, dp request and lit anode pattern.
  always_comb begin
    w_nib    = 4'h0;
    w_cur_dp = 1'b0;
    w_an_lit = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == r_idx) begin
        w_nib    = w_dig[4*k +: 4];
        w_cur_dp = w_dp[k];
        if (!w_supp[k]) w_an_lit[k] = 1'b0;
      end
    end
  end

  // Slot FSM, frame snapshot and registered pin drivers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_BLANK;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_dig     <= '0;
      r_dp_snap <= '0;
      r_en_snap <= '0;
      r_lz_snap <= 1'b0;
      r_an      <= '1;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_scan    <= '0;
    end else begin
      if (w_load) begin
        r_dig     <= digits_i;
        r_dp_snap <= dp_i;
        r_en_snap <= en_i;
        r_lz_snap <= lz_blank_i;
      end
      if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_state <= ST_BLANK;
        r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt   <= w_cnt_inc;
        r_state <= (w_cnt_inc >= BLANK_C) ? ST_ON : ST_BLANK;
      end
      r_an   <= (r_state == ST_ON) ? w_an_lit : '1;
      r_seg  <= hex7(w_nib);
      r_dp   <= ~w_cur_dp;
      r_scan <= r_idx;
    end
  end

  assign an_o       = r_an;
  assign seg_o      = r_seg;
  assign dp_o       = r_dp;
  assign scan_idx_o = r_scan;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with N_DIGITS=8, REFRESH_DIV=8,
// BLANK_CYCLES=2. Edge t counts rising edges from the first one after reset
// release. The pins after edge t show slot t/8 at in-slot position t%8.
module tb_ssd_scan_driver;

  localparam int N = 8;
  localparam int R = 8;
  localparam int B = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   digits_i = '0;
  logic [7:0]    dp_i = '0;
  logic [7:0]    en_i = '0;
  logic          lz_blank_i = 1'b0;
  logic [7:0]    an_o;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [2:0]    scan_idx_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int t_edge = 0;

  logic [6:0] seg_lo [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [6:0] seg_hi [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] seg_lz [8] = '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  ssd_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rstn(rstn), .digits_i(digits_i), .dp_i(dp_i), .en_i(en_i),
    .lz_blank_i(lz_blank_i), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o),
    .scan_idx_o(scan_idx_o)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;

  // Display invariants on every edge: at most one anode low, none low in blanking.
  always begin
    @(posedge clk);
    if (rstn) begin
      int e;
      e = t_edge;
      t_edge = t_edge + 1;
      #1;
      n_cmp = n_cmp + 1;
      if ($countones(~an_o) > 1) begin
        n_fail = n_fail + 1;
        $display("FAIL onehot_anode edge %0d: an_o=%h, required at most one low", e, an_o);
      end
      if ((e % R) < B) begin
        n_cmp = n_cmp + 1;
        if (an_o !== 8'hFF) begin
          n_fail = n_fail + 1;
          $display("FAIL blank_anode edge %0d: an_o=%h, required ff", e, an_o);
        end
      end
    end else begin
      t_edge = 0;
    end
  end

  // Driver: hold reset for two cycles, release on a falling edge.
  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    n_cmp = n_cmp + 4;
    if (an_o !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h want ff", an_o); end
    if (seg_o !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg_o); end
    if (dp_o !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp_o); end
    if (scan_idx_o !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", scan_idx_o); end
  endtask

  task automatic test_hex_low();
    logic [7:0] ea;
    digits_i = 32'h76543210; en_i = 8'hFF; dp_i = 8'h00; lz_blank_i = 1'b0;
    do_reset();
    for (int t = 0; t < 2*N*R; t++) begin
      int s, p;
      @(posedge clk); #1;
      s = (t / R) % N; p = t % R;
      ea = 8'hFF; if (p >= B) ea[s] = 1'b0;
      n_cmp = n_cmp + 4;
      if (an_o !== ea) begin n_fail++; $display("FAIL hex_low_an t=%0d: got %h want %h", t, an_o, ea); end
      if (seg_o !== seg_lo[s]) begin n_fail++; $display("FAIL hex_low_seg t=%0d: got %h want %h", t, seg_o, seg_lo[s]); end
      if (dp_o !== 1'b1) begin n_fail++; $display("FAIL hex_low_dp t=%0d: got %b want 1", t, dp_o); end
      if (scan_idx_o !== 3'(s)) begin n_fail++; $display("FAIL hex_low_idx t=%0d: got %0d want %0d", t, scan_idx_o, s); end
    end
  endtask

  task automatic test_hex_high();
    logic [7:0] ea;
    digits_i = 32'hFEDCBA98; en_i = 8'hFF; dp_i = 8'h00; lz_blank_i = 1'b0;
    do_reset();
    for (int t = 0; t < N*R; t++) begin
      int s, p;
      @(posedge clk); #1;
      s = t / R; p = t % R;
      ea = 8'hFF; if (p >= B) ea[s] = 1'b0;
      n_cmp = n_cmp + 2;
      if (an_o !== ea) begin n_fail++; $display("FAIL hex_high_an t=%0d: got %h want %h", t, an_o, ea); end
      if (seg_o !== seg_hi[s]) begin n_fail++; $display("FAIL hex_high_seg t=%0d: got %h want %h", t, seg_o, seg_hi[s]); end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] ea;
    digits_i = 32'h00000A05; en_i = 8'hFF; dp_i = 8'h00; lz_blank_i = 1'b1;
    do_reset();
    for (int t = 0; t < N*R; t++) begin
      int s, p;
      @(posedge clk); #1;
      s = t / R; p = t % R;
      ea = 8'hFF; if (p >= B && s <= 2) ea[s] = 1'b0;
      n_cmp = n_cmp + 2;
      if (an_o !== ea) begin n_fail++; $display("FAIL lz_an t=%0d: got %h want %h", t, an_o, ea); end
      if (seg_o !== seg_lz[s]) begin n_fail++; $display("FAIL lz_seg t=%0d: got %h want %h", t, seg_o, seg_lz[s]); end
    end
    digits_i = 32'h00000000;
    do_reset();
    for (int t = 0; t < N*R; t++) begin
      int s, p;
      @(posedge clk); #1;
      s = t / R; p = t % R;
      ea = 8'hFF; if (p >= B && s == 0) ea[0] = 1'b0;
      n_cmp = n_cmp + 2;
      if (an_o !== ea) begin n_fail++; $display("FAIL lz_zero_an t=%0d: got %h want %h", t, an_o, ea); end
      if (seg_o !== 7'h40) begin n_fail++; $display("FAIL lz_zero_seg t=%0d: got %h want 40", t, seg_o); end
    end
    lz_blank_i = 1'b0;
  endtask

  task automatic test_enable_dp();
    logic [7:0] ea;
    logic       ed;
    digits_i = 32'h76543210; en_i = 8'h0F; dp_i = 8'h02; lz_blank_i = 1'b0;
    do_reset();
    for (int t = 0; t < N*R; t++) begin
      int s, p;
      @(posedge clk); #1;
      s = t / R; p = t % R;
      ea = 8'hFF; if (p >= B && s < 4) ea[s] = 1'b0;
      ed = (s == 1) ? 1'b0 : 1'b1;
      n_cmp = n_cmp + 3;
      if (an_o !== ea) begin n_fail++; $display("FAIL en_an t=%0d: got %h want %h", t, an_o, ea); end
      if (dp_o !== ed) begin n_fail++; $display("FAIL en_dp t=%0d: got %b want %b", t, dp_o, ed); end
      if (seg_o !== seg_lo[s]) begin n_fail++; $display("FAIL en_seg t=%0d: got %h want %h", t, seg_o, seg_lo[s]); end
    end
    en_i = 8'hFF; dp_i = 8'h00;
  endtask

  task automatic test_midframe_change();
    logic [7:0] ea;
    logic [6:0] es;
    digits_i = 32'h00000000; en_i = 8'hFF; dp_i = 8'h00; lz_blank_i = 1'b0;
    do_reset();
    for (int t = 0; t < 2*N*R; t++) begin
      int s, p;
      @(posedge clk); #1;
      s = (t / R) % N; p = t % R;
      ea = 8'hFF; if (p >= B) ea[s] = 1'b0;
      es = (t < N*R) ? 7'h40 : 7'h79;
      n_cmp = n_cmp + 2;
      if (an_o !== ea) begin n_fail++; $display("FAIL mid_an t=%0d: got %h want %h", t, an_o, ea); end
      if (seg_o !== es) begin n_fail++; $display("FAIL mid_seg t=%0d: got %h want %h", t, seg_o, es); end
      if (t == 3*R + 2) digits_i = 32'h11111111;
    end
  endtask

  task automatic test_reset_midslot();
    logic [7:0] ea;
    digits_i = 32'h76543210; en_i = 8'hFF; dp_i = 8'h00; lz_blank_i = 1'b0;
    do_reset();
    for (int t = 0; t <= 5*R + 4; t++) begin
      @(posedge clk); #1;
    end
    n_cmp = n_cmp + 1;
    if (an_o !== 8'hDF) begin n_fail++; $display("FAIL rmid_pre_an: got %h want df", an_o); end
    #3;
    rstn = 1'b0;
    #1;
    n_cmp = n_cmp + 4;
    if (an_o !== 8'hFF) begin n_fail++; $display("FAIL rmid_an: got %h want ff", an_o); end
    if (seg_o !== 7'h7F) begin n_fail++; $display("FAIL rmid_seg: got %h want 7f", seg_o); end
    if (dp_o !== 1'b1) begin n_fail++; $display("FAIL rmid_dp: got %b want 1", dp_o); end
    if (scan_idx_o !== 3'd0) begin n_fail++; $display("FAIL rmid_idx: got %0d want 0", scan_idx_o); end
    digits_i = 32'hFEDCBA98;
    do_reset();
    for (int t = 0; t < 2*R; t++) begin
      int s, p;
      @(posedge clk); #1;
      s = t / R; p = t % R;
      ea = 8'hFF; if (p >= B) ea[s] = 1'b0;
      n_cmp = n_cmp + 3;
      if (an_o !== ea) begin n_fail++; $display("FAIL rmid_post_an t=%0d: got %h want %h", t, an_o, ea); end
      if (seg_o !== seg_hi[s]) begin n_fail++; $display("FAIL rmid_post_seg t=%0d: got %h want %h", t, seg_o, seg_hi[s]); end
      if (scan_idx_o !== 3'(s)) begin n_fail++; $display("FAIL rmid_post_idx t=%0d: got %0d want %0d", t, scan_idx_o, s); end
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_hex_low();
    test_hex_high();
    test_leading_zero();
    test_enable_dp();
    test_midframe_change();
    test_reset_midslot();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
